medikit_scheduler: RTL
======================

// Module: medikit_scheduler
// PURPOSE
//   Parametrised medication reminder controller for the pill-box design.
//   Programs SLOTS dose times per medicine kind for NUM_KINDS kinds, then
//   compares them against the wall-clock time on every time tick.
//   Raises a per-kind alarm and counts doses taken (acknowledged) and
//   missed (timed out). Sits between the debounced button/clock front end
//   and the seven-segment/LED display logic.
// PARAMETERS
//   NUM_KINDS  3   number of medicine kinds (alarm channels)
//   SLOTS      2   programmable dose times per kind
//   TW         7   width of each time field (t_hi, t_lo)
//   CW         4   width of each taken/missed counter (saturating)
//   TIMEOUT    10  ticks in ALERT without acknowledge before dose counts as missed (>=1)
//   IW         $clog2(NUM_KINDS*SLOTS)  slot index width (derived, localparam)
// PORTS
//   clkin       in   1               system clock, all logic on posedge
//   rst_n       in   1               reset, asynchronous, active-low
//   run         in   1               level: 1 = operate, 0 = return to IDLE and clear
//   btn_next    in   1               store current time into current slot, advance (rising edge)
//   btn_skip    in   1               mark current slot unused, advance (rising edge)
//   btn_take    in   1               acknowledge pending alarms (rising edge)
//   tick        in   1               one-cycle strobe, one per time unit (minute)
//   t_hi        in   TW              current time, high field (hour)
//   t_lo        in   TW              current time, low field (minute)
//   rd_idx      in   IW              slot readback select (kind*SLOTS + slot)
//   state_out   out  2               FSM state encoding
//   prog_idx    out  IW              slot currently being programmed
//   alarm       out  NUM_KINDS       pending alarm per kind
//   taken_cnt   out  NUM_KINDS*CW    doses taken, kind k at [k*CW +: CW]
//   missed_cnt  out  NUM_KINDS*CW    doses missed, same packing
//   rd_hi/rd_lo out  TW each         stored time of slot rd_idx (combinational)
//   rd_valid    out  1               slot rd_idx programmed; all rd_* 0 if rd_idx out of range
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE, prog_idx 0, alarm 0, all counters 0,
//     all slots invalid and zero, button edge registers 0, timer 0.
//   - Buttons are synchronous to clkin; edge = btn & ~btn_q (one registered stage).
//   - States: IDLE=0, PROG=1, ARMED=2, ALERT=3. run=0 in any state -> IDLE next
//     cycle; IDLE clears slots, counters, alarm, prog_idx every cycle.
//   - IDLE: run=1 -> PROG, prog_idx=0.
//   - PROG: next edge: slot[prog_idx] <= {t_hi,t_lo}, valid=1; skip edge: valid=0.
//     Both in same cycle: next wins. Either advances prog_idx; on the last slot
//     (NUM_KINDS*SLOTS-1) -> ARMED, prog_idx stays at last. tick/take ignored.
//   - ARMED: on tick, kind k matches if any valid slot of k equals {t_hi,t_lo};
//     matched bits set in alarm the cycle after tick; any match -> ALERT, timer=0.
//     Matching only on tick cycles (one trigger per time unit).
//   - ALERT: take edge: taken_cnt[k]++ for each set alarm bit, alarm<=0, -> ARMED.
//     tick (no take): new matches OR'd into alarm (timer not restarted); timer++;
//     when timer reaches TIMEOUT: missed_cnt[k]++ for each set bit, alarm<=0, -> ARMED.
//     take and tick same cycle: take wins, tick fully ignored.
//   - Counters saturate at 2^CW-1, never wrap. Timer width $clog2(TIMEOUT+1).
//   - All outputs except rd_* registered; alarm latency = 1 cycle after tick.
// TESTING
//   1 reset mid-ALERT (alarm=001, taken=3) -> all outputs 0, state 0 immediately.
//   2 program NUM_KINDS=3,SLOTS=2: next@8:00, skip, next@12:30, skip x3 -> ARMED;
//     rd_idx=2 -> 12/30 valid; rd_idx=1 -> rd_valid=0.
//   3 tick at 8:00 -> alarm=001 next cycle; take edge -> taken[0]=1, state ARMED.
//   4 kinds 0,2 both at 9:00, tick -> alarm=101; 10 ticks no take -> missed[0]=missed[2]=1.
//   5 take and tick same cycle in ALERT -> only taken increments; 16 takes on CW=4 -> 15.
//   6 run low during PROG at prog_idx=3 -> IDLE, slots invalid, prog_idx 0.

Source files
------------

// File: rtl/medikit_scheduler_if.sv
// Signal bundle between the pill-box button/clock front end, the display
// logic and the medication reminder scheduler.
interface medikit_scheduler_if #(
    parameter int NUM_KINDS = 3,
    parameter int SLOTS     = 2,
    parameter int TW        = 7,
    parameter int CW        = 4
);
    localparam int NSLOT = NUM_KINDS * SLOTS;
    localparam int IW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    logic                    run;
    logic                    btn_next;
    logic                    btn_skip;
    logic                    btn_take;
    logic                    tick;
    logic [TW-1:0]           t_hi;
    logic [TW-1:0]           t_lo;
    logic [IW-1:0]           rd_idx;

    logic [1:0]              state_out;
    logic [IW-1:0]           prog_idx;
    logic [NUM_KINDS-1:0]    alarm;
    logic [NUM_KINDS*CW-1:0] taken_cnt;
    logic [NUM_KINDS*CW-1:0] missed_cnt;
    logic [TW-1:0]           rd_hi;
    logic [TW-1:0]           rd_lo;
    logic                    rd_valid;

    modport master (
        output run, btn_next, btn_skip, btn_take, tick, t_hi, t_lo, rd_idx,
        input  state_out, prog_idx, alarm, taken_cnt, missed_cnt, rd_hi, rd_lo, rd_valid
    );

    modport slave (
        input  run, btn_next, btn_skip, btn_take, tick, t_hi, t_lo, rd_idx,
        output state_out, prog_idx, alarm, taken_cnt, missed_cnt, rd_hi, rd_lo, rd_valid
    );
endinterface

// File: rtl/medikit_scheduler.sv
// Medication reminder controller: dose times are programmed slot by slot,
// then compared against wall-clock time on every tick. Matching kinds raise
// an alarm that is either acknowledged (taken) or times out (missed).
module medikit_scheduler #(
    parameter int NUM_KINDS = 3,
    parameter int SLOTS     = 2,
    parameter int TW        = 7,
    parameter int CW        = 4,
    parameter int TIMEOUT   = 10
) (
    input  logic               clkin,
    input  logic               rst_n,
    medikit_scheduler_if.slave bus
);
    localparam int NSLOT = NUM_KINDS * SLOTS;
    localparam int IW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int TMW   = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]  LAST_IDX  = IW'(NSLOT - 1);
    localparam logic [TMW-1:0] TIMEOUT_V = TMW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROG  = 2'd1,
        ARMED = 2'd2,
        ALERT = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    btn_next_p1, btn_skip_p1, btn_take_p1;
    logic                    next_edge, skip_edge, take_edge;
    logic [TW-1:0]           slot_hi [NSLOT];
    logic [TW-1:0]           slot_lo [NSLOT];
    logic [NSLOT-1:0]        slot_vld;
    logic [IW-1:0]           prog_idx_q;
    logic [NUM_KINDS-1:0]    alarm_q;
    logic [NUM_KINDS-1:0]    match;
    logic [NUM_KINDS*CW-1:0] taken_q, missed_q;
    logic [TMW-1:0]          timer_q, timer_inc;
    logic                    clear;
    logic                    timeout_hit;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    assign next_edge   = bus.btn_next & ~btn_next_p1;
    assign skip_edge   = bus.btn_skip & ~btn_skip_p1;
    assign take_edge   = bus.btn_take & ~btn_take_p1;
    assign clear       = !bus.run || (state_q == IDLE);
    assign timer_inc   = timer_q + TMW'(1);
    assign timeout_hit = (timer_inc == TIMEOUT_V);

    // Per-kind match: any programmed slot of the kind equals the current time.
    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_KINDS; k++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (slot_vld[k*SLOTS+s] && slot_hi[k*SLOTS+s] == bus.t_hi &&
                    slot_lo[k*SLOTS+s] == bus.t_lo) begin
                    match[k] = 1'b1;
                end
            end
        end
    end

    // Next-state logic; run low always forces a return to IDLE.
    always_comb begin
        state_d = state_q;
        if (!bus.run) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PROG;
                PROG:    if ((next_edge || skip_edge) && prog_idx_q == LAST_IDX) state_d = ARMED;
                ARMED:   if (bus.tick && |match) state_d = ALERT;
                ALERT: begin
                    if (take_edge)                       state_d = ARMED;
                    else if (bus.tick && timeout_hit)    state_d = ARMED;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // One registered stage per button for rising-edge detection.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            btn_next_p1 <= 1'b0;
            btn_skip_p1 <= 1'b0;
            btn_take_p1 <= 1'b0;
        end else begin
            btn_next_p1 <= bus.btn_next;
            btn_skip_p1 <= bus.btn_skip;
            btn_take_p1 <= bus.btn_take;
        end
    end

    // Slot storage, programming index, alarm, timer and dose counters.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_hi[i] <= '0;
                slot_lo[i] <= '0;
            end
            slot_vld   <= '0;
            prog_idx_q <= '0;
            alarm_q    <= '0;
            timer_q    <= '0;
            taken_q    <= '0;
            missed_q   <= '0;
        end else if (clear) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_hi[i] <= '0;
                slot_lo[i] <= '0;
            end
            slot_vld   <= '0;
            prog_idx_q <= '0;
            alarm_q    <= '0;
            timer_q    <= '0;
            taken_q    <= '0;
            missed_q   <= '0;
        end else begin
            case (state_q)
                PROG: begin
                    if (next_edge || skip_edge) begin
                        slot_vld[prog_idx_q] <= next_edge;
                        if (next_edge) begin
                            slot_hi[prog_idx_q] <= bus.t_hi;
                            slot_lo[prog_idx_q] <= bus.t_lo;
                        end
                        if (prog_idx_q != LAST_IDX) prog_idx_q <= prog_idx_q + IW'(1);
                    end
                end
                ARMED: begin
                    if (bus.tick && |match) begin
                        alarm_q <= match;
                        timer_q <= '0;
                    end
                end
                ALERT: begin
                    if (take_edge) begin
                        for (int k = 0; k < NUM_KINDS; k++) begin
                            if (alarm_q[k]) taken_q[k*CW +: CW] <= sat_inc(taken_q[k*CW +: CW]);
                        end
                        alarm_q <= '0;
                    end else if (bus.tick) begin
                        if (timeout_hit) begin
                            for (int k = 0; k < NUM_KINDS; k++) begin
                                if (alarm_q[k] || match[k])
                                    missed_q[k*CW +: CW] <= sat_inc(missed_q[k*CW +: CW]);
                            end
                            alarm_q <= '0;
                        end else begin
                            alarm_q <= alarm_q | match;
                            timer_q <= timer_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational readback of one slot; out-of-range indices read as zero.
    always_comb begin
        bus.rd_hi    = '0;
        bus.rd_lo    = '0;
        bus.rd_valid = 1'b0;
        if (int'(bus.rd_idx) < NSLOT) begin
            bus.rd_hi    = slot_hi[bus.rd_idx];
            bus.rd_lo    = slot_lo[bus.rd_idx];
            bus.rd_valid = slot_vld[bus.rd_idx];
        end
    end

    assign bus.state_out  = state_q;
    assign bus.prog_idx   = prog_idx_q;
    assign bus.alarm      = alarm_q;
    assign bus.taken_cnt  = taken_q;
    assign bus.missed_cnt = missed_q;
endmodule
